// File: rtl/witf_pkg.sv
// Shared types and constants for the write-in-flight table.
package witf_pkg;

   localparam int REG_W          = 5;
   localparam int WITF_DEPTH_DEF = 4;

   // One tracking slot: a valid bit and the destination register index.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
   } witf_entry_t;

endpackage

// File: rtl/witf_match.sv
// Compares one source register index against every table entry.
// Entries flagged in excl_i are skipped, so a retiring head can be hidden.
// Register zero never matches.
module witf_match
   import witf_pkg::*;
#(
   parameter int DEPTH = WITF_DEPTH_DEF
) (
   input  logic [REG_W-1:0]        src_i,
   input  witf_entry_t [DEPTH-1:0] ent_i,
   input  logic [DEPTH-1:0]        excl_i,
   output logic                    hit_o
);

   logic [DEPTH-1:0] lane_hit;

   for (genvar i = 0; i < DEPTH; i++) begin : g_lane
      assign lane_hit[i] = ent_i[i].valid & ~excl_i[i] & (ent_i[i].rd == src_i);
   end

   assign hit_o = (src_i != '0) & (|lane_hit);

endmodule

// File: rtl/witf.sv
// Write-in-flight table: in-order scoreboard of destination registers that
// have been dispatched but not yet written back. Flags RAW hazards for decode
// and reports full/empty/count for dispatch stalling.
// Optional macro WITF_BYPASS_EN: hide the head entry from matching in the
// cycle it retires, so a stalled consumer is released in that same cycle.
module witf
   import witf_pkg::*;
#(
   parameter  int DEPTH = WITF_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_W-1:0] rd,
   input  logic             disp_en,
   input  logic             wb_en,
   input  logic [REG_W-1:0] wb_rd,
   output logic             isRAW,
   output logic             witf_full,
   output logic             witf_empty,
   output logic [PTR_W:0]   witf_cnt,
   output logic             witf_err
);

   witf_entry_t [DEPTH-1:0] ent_q, ent_d;
   logic [PTR_W-1:0]        hd_q, hd_d, tl_q, tl_d;
   logic [PTR_W:0]          cnt_q, cnt_d;
   logic                    err_q, err_d;

   logic             push, pop;
   logic [DEPTH-1:0] excl;
   logic [1:0]       hit;
   logic [1:0][REG_W-1:0] src;

   // Full/empty come only from registered count: a same-cycle pop never
   // makes room for a push.
   assign witf_full  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign witf_empty = (cnt_q == '0);
   assign witf_cnt   = cnt_q;
   assign witf_err   = err_q;

   assign push = disp_en & ~witf_full;
   assign pop  = wb_en & ~witf_empty;

   // Exclusion mask for the retiring head (bypass build only).
   always_comb begin
      excl = '0;
`ifdef WITF_BYPASS_EN
      if (wb_en) excl[hd_q] = 1'b1;
`endif
   end

   assign src = {rs2, rs1};

   for (genvar s = 0; s < 2; s++) begin : g_src
      witf_match #(.DEPTH(DEPTH)) u_match (
         .src_i  (src[s]),
         .ent_i  (ent_q),
         .excl_i (excl),
         .hit_o  (hit[s])
      );
   end

   assign isRAW = |hit;

   // Next state: push at tail, pop at head, sticky error on misuse.
   // Push and pop never target the same slot: hd==tl only when full
   // (push refused) or empty (pop refused).
   always_comb begin
      ent_d = ent_q;
      hd_d  = hd_q;
      tl_d  = tl_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (push) begin
         ent_d[tl_q] = '{valid: 1'b1, rd: rd};
         tl_d        = tl_q + PTR_W'(1);
      end
      if (pop) begin
         ent_d[hd_q].valid = 1'b0;
         hd_d              = hd_q + PTR_W'(1);
         if (wb_rd != ent_q[hd_q].rd) err_d = 1'b1;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      if (disp_en & witf_full) err_d = 1'b1;
      if (wb_en & witf_empty)  err_d = 1'b1;
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_q <= '0;
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         ent_q <= ent_d;
         hd_q  <= hd_d;
         tl_q  <= tl_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_witf.sv
// Bench for witf: directed scenarios then random traffic, checked against a
// queue-based model of the in-flight destination list.
module tb_witf;

   localparam int DEPTH = 4;

`ifdef WITF_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0, wb_rd = '0;
   logic       disp_en = 1'b0, wb_en = 1'b0;
   logic       isRAW, witf_full, witf_empty, witf_err;
   logic [2:0] witf_cnt;

   int errors = 0;
   int checks = 0;

   logic [4:0] mq[$];
   logic       merr = 1'b0;

   witf #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
      .disp_en(disp_en), .wb_en(wb_en), .wb_rd(wb_rd),
      .isRAW(isRAW), .witf_full(witf_full), .witf_empty(witf_empty),
      .witf_cnt(witf_cnt), .witf_err(witf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hazard per the rules: any in-flight rd equal to a nonzero source,
   // except the retiring oldest one when bypass is built in.
   function automatic logic mraw(input logic [4:0] a, input logic [4:0] b, input logic wb);
      for (int i = 0; i < mq.size(); i++) begin
         if (BYP && wb && i == 0) continue;
         if (a != 0 && mq[i] == a) return 1'b1;
         if (b != 0 && mq[i] == b) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drive(input logic d, input logic [4:0] r, input logic w,
                        input logic [4:0] wr, input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      disp_en = d; rd = r; wb_en = w; wb_rd = wr; rs1 = a; rs2 = b;
      #1;
   endtask

   task automatic commit();
      bit f, e;
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      chk("m_raw",   32'(isRAW),      32'(mraw(rs1, rs2, wb_en)));
      chk("m_full",  32'(witf_full),  32'(f));
      chk("m_empty", 32'(witf_empty), 32'(e));
      chk("m_cnt",   32'(witf_cnt),   32'(mq.size()));
      chk("m_err",   32'(witf_err),   32'(merr));
      if (disp_en && f) merr = 1'b1;
      if (wb_en) begin
         if (e) merr = 1'b1;
         else begin
            if (wb_rd != mq[0]) merr = 1'b1;
            void'(mq.pop_front());
         end
      end
      if (disp_en && !f) mq.push_back(rd);
      @(posedge clk);
   endtask

   task automatic step(input logic d, input logic [4:0] r, input logic w,
                       input logic [4:0] wr, input logic [4:0] a, input logic [4:0] b);
      drive(d, r, w, wr, a, b);
      commit();
   endtask

   // Assert reset between edges, check outputs before any edge, then release.
   task automatic do_reset(input string tag);
      #1;
      rst = 1'b0; disp_en = 1'b0; wb_en = 1'b0;
      #1;
      chk({tag, "_raw"},   32'(isRAW),      0);
      chk({tag, "_full"},  32'(witf_full),  0);
      chk({tag, "_empty"}, 32'(witf_empty), 1);
      chk({tag, "_cnt"},   32'(witf_cnt),   0);
      chk({tag, "_err"},   32'(witf_err),   0);
      mq.delete();
      merr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_raw",   32'(isRAW),      0);
      chk("rst_full",  32'(witf_full),  0);
      chk("rst_empty", 32'(witf_empty), 1);
      chk("rst_cnt",   32'(witf_cnt),   0);
      chk("rst_err",   32'(witf_err),   0);
      @(negedge clk);
      rst = 1'b1;

      // Push 5, hazard next cycle, writeback clears it
      step(1, 5, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 5, 0);
      chk("push_raw", 32'(isRAW), 1);
      commit();
      drive(0, 0, 1, 5, 5, 0);
      chk("wb_same_raw", 32'(isRAW), 32'(!BYP));
      commit();
      drive(0, 0, 0, 0, 5, 0);
      chk("pop_raw", 32'(isRAW), 0);
      chk("pop_empty", 32'(witf_empty), 1);
      commit();

      // Fill and overflow
      for (int i = 1; i <= 4; i++) step(1, 5'(i), 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("fill_full", 32'(witf_full), 1);
      chk("fill_cnt",  32'(witf_cnt), 4);
      commit();
      step(1, 6, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 6);
      chk("ovf_err", 32'(witf_err), 1);
      chk("ovf_raw", 32'(isRAW), 0);
      commit();
      for (int i = 1; i <= 4; i++) step(0, 0, 1, 5'(i), 0, 0);
      do_reset("rst_a");

      // Wrap with simultaneous push/pop at cnt=2
      step(1, 1, 0, 0, 0, 0);
      step(1, 2, 0, 0, 0, 0);
      step(1, 3, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("sim_cnt", 32'(witf_cnt), 2);
      commit();
      step(1, 4, 0, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0);
      step(0, 0, 1, 2, 0, 0);
      step(0, 0, 1, 3, 0, 0);
      step(1, 6, 1, 4, 0, 0);
      step(1, 7, 0, 0, 0, 0);
      for (int i = 5; i <= 7; i++) step(0, 0, 1, 5'(i), 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("wrap_err", 32'(witf_err), 0);
      chk("wrap_empty", 32'(witf_empty), 1);
      commit();

      // Bypass on head rd=9
      step(1, 9, 0, 0, 0, 0);
      drive(0, 0, 1, 9, 9, 0);
      chk("byp_raw", 32'(isRAW), 32'(!BYP));
      commit();

      // Register zero and duplicates
      step(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("zero_raw", 32'(isRAW), 0);
      commit();
      step(0, 0, 1, 0, 0, 0);
      step(1, 3, 0, 0, 0, 0);
      step(1, 3, 0, 0, 0, 0);
      step(0, 0, 1, 3, 0, 0);
      drive(0, 0, 0, 0, 3, 0);
      chk("dup_raw", 32'(isRAW), 1);
      commit();
      step(0, 0, 1, 3, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("dup_err", 32'(witf_err), 0);
      commit();

      // Writeback mismatch
      step(1, 4, 0, 0, 0, 0);
      step(0, 0, 1, 8, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("mis_err", 32'(witf_err), 1);
      commit();
      do_reset("rst_b");

      // Underflow
      step(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("unf_err", 32'(witf_err), 1);
      chk("unf_empty", 32'(witf_empty), 1);
      commit();
      do_reset("rst_c");

      // Mid-run reset with a live hazard on rs1
      step(1, 2, 0, 0, 0, 0);
      step(1, 3, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 2, 0);
      chk("mid_raw_pre", 32'(isRAW), 1);
      do_reset("rst_mid");

      // Random traffic, mostly correct writebacks
      for (int n = 0; n < 500; n++) begin
         logic [4:0] wr;
         if (n % 125 == 124) do_reset("rst_rnd");
         wr = (mq.size() != 0 && $urandom_range(19) != 0) ? mq[0] : 5'($urandom_range(7));
         step(1'($urandom_range(1)), 5'($urandom_range(7)),
              1'($urandom_range(9) < 4), wr,
              5'($urandom_range(7)), 5'($urandom_range(7)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
